// File: rtl/imm_gen_skid_if.sv
// Handshake bundle for imm_gen_skid.
// Input side : ImmSrc, data_in, in_valid (producer -> block), in_ready (block -> producer).
// Output side: data_out, out_illegal, out_valid, illegal_seen (block -> consumer), out_ready (consumer -> block).
// The slave modport is the block; the master modport is whoever drives instructions and consumes immediates.
interface imm_gen_skid_if #(
  parameter int unsigned XLEN = 32
);
  logic [2:0]      ImmSrc;
  logic [31:0]     data_in;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] data_out;
  logic            out_illegal;
  logic            out_valid;
  logic            out_ready;
  logic            illegal_seen;

  modport slave (
    input  ImmSrc, data_in, in_valid, out_ready,
    output in_ready, data_out, out_illegal, out_valid, illegal_seen
  );

  modport master (
    output ImmSrc, data_in, in_valid, out_ready,
    input  in_ready, data_out, out_illegal, out_valid, illegal_seen
  );
endinterface

// File: rtl/imm_gen_skid.sv
// RISC-V immediate generator with a two-entry output skid buffer.
// Ports: clk, reset (synchronous, active-high), bus (imm_gen_skid_if.slave).
// The instruction word is decoded combinationally and the result is held in the
// OUT register; a second SKID register absorbs one beat while the consumer stalls.
// in_ready depends only on registered state and reset, never on out_ready.
// XLEN must be 32 or 64.
module imm_gen_skid #(
  parameter int unsigned XLEN = 32
) (
  input  logic          clk,
  input  logic          reset,
  imm_gen_skid_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  logic            out_ill_q, out_ill_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  logic            skid_ill_q, skid_ill_d;
  logic            out_valid_q, out_valid_d;
  logic            illegal_seen_q, illegal_seen_d;

  logic [XLEN-1:0] dec_imm_c;
  logic            dec_ill_c;
  logic            in_ready_c;
  logic            accept_c;
  logic            xfer_c;
  logic            unused_opcode_c;

  // Opcode bits never feed any immediate format.
  assign unused_opcode_c = ^bus.data_in[6:0];

  // Format decode: start from a full sign fill, then overwrite the low field.
  always_comb begin
    dec_imm_c = {XLEN{bus.data_in[31]}};
    dec_ill_c = 1'b0;
    case (bus.ImmSrc)
      3'b000: dec_imm_c[11:0] = bus.data_in[31:20];
      3'b001: dec_imm_c[11:0] = {bus.data_in[31:25], bus.data_in[11:7]};
      3'b010: dec_imm_c[12:0] = {bus.data_in[31], bus.data_in[7], bus.data_in[30:25],
                                 bus.data_in[11:8], 1'b0};
      3'b011: dec_imm_c[31:0] = {bus.data_in[31:12], 12'h000};
      3'b100: dec_imm_c[20:0] = {bus.data_in[31], bus.data_in[19:12], bus.data_in[20],
                                 bus.data_in[30:21], 1'b0};
      3'b101: begin
        dec_imm_c      = '0;
        dec_imm_c[4:0] = bus.data_in[19:15];
      end
      default: begin
        dec_imm_c = '0;
        dec_ill_c = 1'b1;
      end
    endcase
  end

  // Ready comes from state only, so no out_ready -> in_ready path exists.
  assign in_ready_c = (state_q != ST_FULL) && !reset;
  assign accept_c   = bus.in_valid && in_ready_c;
  assign xfer_c     = out_valid_q && bus.out_ready;

  // Buffer next-state and data steering.
  always_comb begin
    state_d        = state_q;
    out_imm_d      = out_imm_q;
    out_ill_d      = out_ill_q;
    skid_imm_d     = skid_imm_q;
    skid_ill_d     = skid_ill_q;
    illegal_seen_d = illegal_seen_q || (accept_c && dec_ill_c);

    case (state_q)
      ST_EMPTY: begin
        if (accept_c) begin
          out_imm_d = dec_imm_c;
          out_ill_d = dec_ill_c;
          state_d   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept_c && xfer_c) begin
          out_imm_d = dec_imm_c;
          out_ill_d = dec_ill_c;
        end else if (accept_c) begin
          skid_imm_d = dec_imm_c;
          skid_ill_d = dec_ill_c;
          state_d    = ST_FULL;
        end else if (xfer_c) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (xfer_c) begin
          out_imm_d = skid_imm_q;
          out_ill_d = skid_ill_q;
          state_d   = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    out_valid_d = (state_d != ST_EMPTY);
  end

  // State and payload registers; reset discards any buffered beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_EMPTY;
      out_imm_q      <= '0;
      out_ill_q      <= 1'b0;
      skid_imm_q     <= '0;
      skid_ill_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      illegal_seen_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      out_imm_q      <= out_imm_d;
      out_ill_q      <= out_ill_d;
      skid_imm_q     <= skid_imm_d;
      skid_ill_q     <= skid_ill_d;
      out_valid_q    <= out_valid_d;
      illegal_seen_q <= illegal_seen_d;
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.data_out     = out_imm_q;
  assign bus.out_illegal  = out_ill_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.illegal_seen = illegal_seen_q;

endmodule

// File: doc/imm_gen_skid.md
# imm_gen_skid

Registered, parametrised immediate generator for the RISC-V decode path. It takes a 32-bit instruction word and a 3-bit format select and produces a sign- or zero-extended immediate of width `XLEN`. It supports the I, S, B, U, J and CSR-zimm formats and flags illegal selects. Input and output use valid/ready handshakes with a two-entry skid buffer, so full throughput is held under backpressure when the core is pipelined.

## Interface
- `XLEN`, default 32: immediate output width; legal values are 32 and 64.
- `clk` input 1: sole clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `ImmSrc` input 3: format select, sampled with `data_in`.
- `data_in` input 32: instruction word.
- `in_valid` input 1: `ImmSrc`/`data_in` valid this cycle.
- `in_ready` output 1: block accepts a beat this cycle.
- `data_out` output XLEN: extended immediate.
- `out_illegal` output 1: the current output beat carried an illegal `ImmSrc`.
- `out_valid` output 1: `data_out`/`out_illegal` valid.
- `out_ready` input 1: consumer accepts the output beat.
- `illegal_seen` output 1: sticky flag; set by any accepted illegal beat, cleared only by reset.

## Operation
- Format decode. Below, s = `data_in[31]` replicated to fill `XLEN`.
  - 000 I: {s, `data_in[31:20]`}
  - 001 S: {s, `data_in[31:25]`, `data_in[11:7]`}
  - 010 B: {s, `data_in[7]`, `data_in[30:25]`, `data_in[11:8]`, 1'b0}. Bit 12 of the immediate comes from `data_in[31]`.
  - 011 U: {s, `data_in[31:12]`, 12'b0}. For `XLEN`=64, bits 63:32 equal `data_in[31]`.
  - 100 J: {s, `data_in[19:12]`, `data_in[20]`, `data_in[30:21]`, 1'b0}
  - 101 Z: zero-extend `data_in[19:15]`. The upper `XLEN`-5 bits are 0.
  - 110, 111: illegal. Immediate is all zeros, `out_illegal`=1.
- Decode is combinational on the input side. Only the registered result is visible at the output.
- Accept condition: `in_valid` && `in_ready`. Output transfer condition: `out_valid` && `out_ready`.
- Storage is two entries, each holding {imm, illegal}:
  - OUT register, which drives the outputs.
  - SKID register, which is internal.
- Buffer states:
  - EMPTY: OUT invalid, SKID invalid.
  - ONE: OUT valid, SKID invalid.
  - FULL: both valid.
- Transitions:
  - EMPTY, accept → ONE; the decoded beat is loaded into OUT.
  - ONE, accept and transfer → ONE; OUT is reloaded with the new beat.
  - ONE, accept, no transfer → FULL; the new beat is loaded into SKID.
  - ONE, transfer, no accept → EMPTY.
  - FULL, transfer → ONE; SKID moves to OUT. No accept is possible in FULL.
  - Otherwise the state holds.
- `in_ready` = (state != FULL) && !`reset`. It is derived from registered state only, with no combinational path from `out_ready`.
- Beats leave in acceptance order. None are dropped or duplicated.
- `illegal_seen` sets in the cycle after an illegal beat is accepted, whether or not that beat has been consumed yet.

## Timing
- Latency is 1 cycle. A beat accepted at edge N is presented on `data_out` with `out_valid`=1 after edge N, provided the buffer was EMPTY or transferring.
- Throughput is 1 beat per cycle while `out_ready`=1.
- Outputs are stable while `out_valid`=1 and `out_ready`=0.
- Reset, including mid-operation:
  - State goes to EMPTY on the next edge; both buffered beats are discarded.
  - `out_valid`=0, `data_out`=0, `out_illegal`=0, `illegal_seen`=0.
  - `in_ready`=0 while `reset` is high, and 1 in the first cycle after release.
- When `reset` is high, no accept occurs even if `in_valid`=1.
- `data_out` holds its last value when `out_valid`=0. Its value is don't-care apart from the reset value.

## Test plan
- **Formats at `XLEN`=32**, `out_ready`=1, one beat per cycle. Each beat must appear one cycle after acceptance:
  - I, `0xFFF00093` → `0xFFFFFFFF`
  - S, `0xFE112E23` → `0xFFFFFFFC`
  - B, `0xFE000CE3` → `0xFFFFFFF8`
  - U, `0x123450B7` → `0x12345000`
  - J, `0x001000EF` → `0x00000800`
  - Z, `data_in[19:15]`=5'b11111 → `0x0000001F`
- **`XLEN`=64:**
  - I, `0xFFF00093` → `0xFFFFFFFFFFFFFFFF`
  - U, `0x800000B7` → `0xFFFFFFFF80000000`
  - Z, `data_in[19:15]`=5'b11111 → `0x000000000000001F`
- **Illegal select:** `ImmSrc`=110 accepted → `data_out`=0, `out_illegal`=1. `illegal_seen`=1 from the next cycle and stays 1 across the following legal beats until reset.
- **Backpressure:** hold `out_ready`=0 and offer 3 beats A, B, C back-to-back.
  - A is in OUT and B in SKID; `in_ready`=0 from the cycle after B is accepted, so C is held.
  - Raise `out_ready`: outputs are A, B, C in consecutive cycles with nothing lost.
- **Reset mid-operation:** in the FULL state, assert `reset` for 1 cycle.
  - Next cycle: `out_valid`=0, `data_out`=0, `illegal_seen`=0, `in_ready`=0 while `reset` is high.
  - After release: `in_ready`=1, and the old beats never appear.
- **Randomised valid/ready** over 10,000 beats against a reference queue model: order preserved, outputs stable under stall, and `in_ready` never depends combinationally on `out_ready`.
